// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared source indices, CDB entry type and defaults for the CDB arbiter
`ifndef CDB_ARBITER_TRUE_FALSE
`define CDB_ARBITER_TRUE_FALSE
`define TRUE  1'b1
`define FALSE 1'b0
`endif

package cdb_arbiter_pkg;

    // Write-stage source indices in arbitration order.
    localparam int SRC_ALU  = 0;
    localparam int SRC_MULT = 1;
    localparam int SRC_LB   = 2;
    localparam int SRC_ACU  = 3;

    localparam int NUM_SRC_DEF   = 4;
    localparam int ROB_IDX_W_DEF = 5;
    localparam int XLEN_DEF      = 32;
    localparam int SRC_W_DEF     = $clog2(NUM_SRC_DEF);

    typedef struct packed {
        logic [ROB_IDX_W_DEF-1:0] tag;
        logic [XLEN_DEF-1:0]      value;
        logic [SRC_W_DEF-1:0]     src;
    } cdb_entry_t;

endpackage

// File: rtl/cdb_arbiter_picker.sv
// rtl/cdb_arbiter_picker.sv - combinational round-robin priority picker
//
// Ports:
//   req        in   NUM_SRC   request vector
//   ptr        in   IDX_W     highest-priority index this cycle (must be < NUM_SRC)
//   grant      out  NUM_SRC   one-hot grant (zero when nothing requested)
//   grant_idx  out  IDX_W     index of the granted request
//   any_grant  out  1         at least one request present
module rr_priority_picker
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_SRC-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_grant
);

    int idx;

    // Scan ptr, ptr+1, ... wrapping at NUM_SRC; the first requester found wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = `FALSE;
        idx       = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            if (!any_grant && req[idx]) begin
                any_grant  = `TRUE;
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbiter of execute write stages onto the registered CDB
//
// Ports:
//   clock, reset     rising-edge clock, asynchronous active-high reset
//   squash           misprediction flush: blocks grants, empties the CDB register
//   src_valid        per-source result held in its write stage
//   src_tag          per-source ROB tag, source i at [i*ROB_IDX_W +: ROB_IDX_W]
//   src_value        per-source result, source i at [i*XLEN +: XLEN]
//   src_written      one-hot combinational grant pulse back to the write stages
//   cdb_ready        consumer accepts the current CDB entry
//   cdb_valid/tag/value/src   registered CDB entry
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_SRC   = NUM_SRC_DEF,
    parameter int ROB_IDX_W = ROB_IDX_W_DEF,
    parameter int XLEN      = XLEN_DEF,
    parameter int SRC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         squash,
    input  logic [NUM_SRC-1:0]           src_valid,
    input  logic [NUM_SRC*ROB_IDX_W-1:0] src_tag,
    input  logic [NUM_SRC*XLEN-1:0]      src_value,
    output logic [NUM_SRC-1:0]           src_written,
    input  logic                         cdb_ready,
    output logic                         cdb_valid,
    output logic [ROB_IDX_W-1:0]         cdb_tag,
    output logic [XLEN-1:0]              cdb_value,
    output logic [SRC_W-1:0]             cdb_src
);

    logic [SRC_W-1:0]     rr_ptr;
    logic [SRC_W-1:0]     rr_ptr_next;
    logic [NUM_SRC-1:0]   pick_grant;
    logic [SRC_W-1:0]     pick_idx;
    logic                 pick_any;
    logic                 can_load;
    logic                 do_grant;
    logic [ROB_IDX_W-1:0] mux_tag;
    logic [XLEN-1:0]      mux_value;

    rr_priority_picker #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (SRC_W)
    ) u_picker (
        .req       (src_valid),
        .ptr       (rr_ptr),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .any_grant (pick_any)
    );

    // The register can take a new entry when empty or when its current entry leaves.
    assign can_load = ~cdb_valid | cdb_ready;
    assign do_grant = can_load & ~squash & ~reset & pick_any;

    // Grant depends only on valid/ready/squash/pointer, never on tag or value.
    assign src_written = do_grant ? pick_grant : '0;

    assign mux_tag   = src_tag[int'(pick_idx)*ROB_IDX_W +: ROB_IDX_W];
    assign mux_value = src_value[int'(pick_idx)*XLEN +: XLEN];

    // Explicit wrap keeps the pointer inside [0, NUM_SRC) for non-power-of-2 counts.
    assign rr_ptr_next = (pick_idx == SRC_W'(NUM_SRC - 1)) ? '0 : pick_idx + 1'b1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_value <= '0;
            cdb_src   <= '0;
            rr_ptr    <= '0;
        end else if (squash) begin
            cdb_valid <= 1'b0;
        end else if (can_load) begin
            if (pick_any) begin
                cdb_valid <= 1'b1;
                cdb_tag   <= mux_tag;
                cdb_value <= mux_value;
                cdb_src   <= pick_idx;
                rr_ptr    <= rr_ptr_next;
            end else begin
                cdb_valid <= 1'b0;
            end
        end
    end

    a_written_onehot0 : assert property (@(posedge clock) disable iff (reset)
        $onehot0(src_written));
    a_written_needs_valid : assert property (@(posedge clock) disable iff (reset)
        (src_written & ~src_valid) == '0);

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed self-checking bench for cdb_arbiter
module tb_cdb_arbiter;

    logic        clock;
    logic        reset;
    logic        squash;
    logic [3:0]  src_valid;
    logic [19:0] src_tag;
    logic [127:0] src_value;
    logic [3:0]  src_written;
    logic        cdb_ready;
    logic        cdb_valid;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic [1:0]  cdb_src;

    int tests_run;
    int tests_failed;

    logic [4:0]  tag_of [4];
    logic [31:0] val_of [4];

    cdb_arbiter dut (
        .clock       (clock),
        .reset       (reset),
        .squash      (squash),
        .src_valid   (src_valid),
        .src_tag     (src_tag),
        .src_value   (src_value),
        .src_written (src_written),
        .cdb_ready   (cdb_ready),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_value   (cdb_value),
        .cdb_src     (cdb_src)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Continuous grant-legality check on every falling edge outside reset.
    always @(negedge clock) begin
        if (!reset) begin
            tests_run++;
            if (!$onehot0(src_written) || (src_written & ~src_valid) != 4'b0) begin
                tests_failed++;
                $display("FAIL grant_legal: src_written=%b src_valid=%b", src_written, src_valid);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        squash    = 1'b0;
        cdb_ready = 1'b0;
        src_valid = 4'b0;
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic chk_written(string name, logic [3:0] exp);
        tests_run++;
        if (src_written !== exp) begin
            tests_failed++;
            $display("FAIL %s: src_written=%b expected %b", name, src_written, exp);
        end
    endtask

    task automatic chk_entry(string name, logic v, logic [1:0] s, logic [4:0] t, logic [31:0] d);
        tests_run++;
        if (cdb_valid !== v || cdb_src !== s || cdb_tag !== t || cdb_value !== d) begin
            tests_failed++;
            $display("FAIL %s: valid=%b src=%0d tag=%0d value=%h expected valid=%b src=%0d tag=%0d value=%h",
                     name, cdb_valid, cdb_src, cdb_tag, cdb_value, v, s, t, d);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        squash    = 1'b0;
        cdb_ready = 1'b0;
        src_valid = 4'b1111;
        #1;
        tests_run++;
        if (src_written !== 4'b0 || cdb_valid !== 1'b0 || cdb_tag !== 5'd0 ||
            cdb_value !== 32'd0 || cdb_src !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_state: written=%b valid=%b tag=%0d value=%h src=%0d expected all zero",
                     src_written, cdb_valid, cdb_tag, cdb_value, cdb_src);
        end
        step();
        reset = 1'b0;
        #1;
        chk_written("reset_first_grant", 4'b0001);
        step();
        chk_entry("reset_first_entry", 1'b1, 2'd0, tag_of[0], val_of[0]);
    endtask

    task automatic test_idle();
        // Entry from test_reset still present; consumer takes it and nobody requests.
        src_valid = 4'b0;
        cdb_ready = 1'b1;
        #1;
        chk_written("idle_no_grant", 4'b0000);
        step();
        chk_entry("idle_valid_drops_data_holds", 1'b0, 2'd0, tag_of[0], val_of[0]);
    endtask

    task automatic test_back_to_back();
        do_reset();
        src_valid = 4'b1111;
        cdb_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk_written($sformatf("b2b_grant_%0d", k), 4'b0001 << (k % 4));
            step();
            chk_entry($sformatf("b2b_entry_%0d", k), 1'b1, 2'(k % 4), tag_of[k % 4], val_of[k % 4]);
        end
    endtask

    task automatic test_stall();
        do_reset();
        src_valid = 4'b0001;
        step();
        src_valid = 4'b0010;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk_written($sformatf("stall_no_grant_%0d", k), 4'b0000);
            step();
            chk_entry($sformatf("stall_hold_%0d", k), 1'b1, 2'd0, tag_of[0], val_of[0]);
        end
        cdb_ready = 1'b1;
        #1;
        chk_written("stall_release_grant", 4'b0010);
        step();
        chk_entry("stall_release_entry", 1'b1, 2'd1, tag_of[1], val_of[1]);
    endtask

    task automatic test_squash();
        do_reset();
        src_valid = 4'b0001;
        step();
        // Pointer now 1. Squash while stalled must empty the CDB and keep the pointer.
        src_valid = 4'b0100;
        squash    = 1'b1;
        #1;
        chk_written("squash_no_grant", 4'b0000);
        step();
        tests_run++;
        if (cdb_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL squash_clears_valid: cdb_valid=%b expected 0", cdb_valid);
        end
        squash    = 1'b0;
        src_valid = 4'b0111;
        #1;
        chk_written("squash_ptr_held", 4'b0010);
        step();
        chk_entry("squash_after_entry", 1'b1, 2'd1, tag_of[1], val_of[1]);
    endtask

    task automatic test_wrap();
        do_reset();
        src_valid = 4'b1111;
        cdb_ready = 1'b1;
        step();
        step();
        step();
        src_valid = 4'b1000;
        #1;
        chk_written("wrap_grant3", 4'b1000);
        step();
        chk_entry("wrap_entry3", 1'b1, 2'd3, tag_of[3], val_of[3]);
        src_valid = 4'b1001;
        #1;
        chk_written("wrap_src0_wins", 4'b0001);
        step();
        chk_entry("wrap_entry0", 1'b1, 2'd0, tag_of[0], val_of[0]);
    endtask

    task automatic test_async_reset();
        do_reset();
        src_valid = 4'b0001;
        step();
        tests_run++;
        if (cdb_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL async_pre_valid: cdb_valid=%b expected 1", cdb_valid);
        end
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if (cdb_valid !== 1'b0 || src_written !== 4'b0) begin
            tests_failed++;
            $display("FAIL async_reset_drop: cdb_valid=%b src_written=%b expected 0 and 0000",
                     cdb_valid, src_written);
        end
        step();
        reset = 1'b0;
        src_valid = 4'b0;
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        tag_of[0] = 5'd3;  tag_of[1] = 5'd7;  tag_of[2] = 5'd9;  tag_of[3] = 5'd12;
        val_of[0] = 32'hA000_0001; val_of[1] = 32'hB000_0002;
        val_of[2] = 32'hC000_0003; val_of[3] = 32'hD000_0004;
        for (int i = 0; i < 4; i++) begin
            src_tag[i*5 +: 5]     = tag_of[i];
            src_value[i*32 +: 32] = val_of[i];
        end
        test_reset();
        test_idle();
        test_back_to_back();
        test_stall();
        test_squash();
        test_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
